// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_pkg: shared widths, forwarding encodings and hazard FSM states for the ID-stage hazard unit.
package pipeline_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_LOAD_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH      = 2'd2;

    typedef enum logic [1:0] {
        HZ_RUN        = S_RUN,
        HZ_LOAD_STALL = S_LOAD_STALL,
        HZ_FLUSH      = S_FLUSH
    } hz_state_e;

    // A load in EX cannot forward yet, so only a non-load EX hit takes the MEM path.
    function automatic logic [1:0] fwd_encode(input logic ex_hit, input logic ex_load_hit, input logic mem_hit);
        return (ex_hit && !ex_load_hit) ? FWD_MEM : mem_hit ? FWD_WB : FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-stage register info in, stall/flush/forward controls and counters out.
interface pipeline_hazard_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = pipeline_pkg::ADDR_W,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_a_addr;
    logic [ADDR_W-1:0] id_b_addr;
    logic              id_a_used;
    logic              id_b_used;
    logic [ADDR_W-1:0] ex_c_addr;
    logic              ex_reg_write;
    logic              ex_data_read;
    logic [ADDR_W-1:0] mem_c_addr;
    logic              mem_reg_write;
    logic              branch_taken;
    logic              stall_pc;
    logic              stall_id;
    logic              flush_if_id;
    logic              bubble_ex;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_valid, id_a_addr, id_b_addr, id_a_used, id_b_used,
        output ex_c_addr, ex_reg_write, ex_data_read, mem_c_addr, mem_reg_write, branch_taken,
        input  stall_pc, stall_id, flush_if_id, bubble_ex, fwd_a_sel, fwd_b_sel, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_a_addr, id_b_addr, id_a_used, id_b_used,
        input  ex_c_addr, ex_reg_write, ex_data_read, mem_c_addr, mem_reg_write, branch_taken,
        output stall_pc, stall_id, flush_if_id, bubble_ex, fwd_a_sel, fwd_b_sel, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_src_cmp.sv
// hazard_src_cmp: per-source compare of one ID operand against the EX and MEM destinations.
module hazard_src_cmp #(
    parameter int ADDR_W = 4
) (
    input  logic              valid_i,
    input  logic              used_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic              ex_we_i,
    input  logic              ex_load_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_we_i,
    output logic              ex_hit_o,
    output logic              ex_load_hit_o,
    output logic              mem_hit_o
);
    logic rd;

    // R0 is hard-wired zero, so it never creates a dependency.
    assign rd            = valid_i && used_i && (addr_i != '0);
    assign ex_hit_o      = rd && ex_we_i && (addr_i == ex_addr_i);
    assign ex_load_hit_o = ex_hit_o && ex_load_i;
    assign mem_hit_o     = rd && mem_we_i && (addr_i == mem_addr_i);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall / branch flush FSM, registered forwarding selects and saturating event counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = pipeline_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipeline_hazard_ctrl_if.slave hz
);
    logic             a_ex, a_ld, a_mem, b_ex, b_ld, b_mem;
    logic             load_use, stall, flush, bubble;
    logic [1:0]       state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    hazard_src_cmp #(.ADDR_W(ADDR_W)) u_cmp_a (
        .valid_i      (hz.id_valid),
        .used_i       (hz.id_a_used),
        .addr_i       (hz.id_a_addr),
        .ex_addr_i    (hz.ex_c_addr),
        .ex_we_i      (hz.ex_reg_write),
        .ex_load_i    (hz.ex_data_read),
        .mem_addr_i   (hz.mem_c_addr),
        .mem_we_i     (hz.mem_reg_write),
        .ex_hit_o     (a_ex),
        .ex_load_hit_o(a_ld),
        .mem_hit_o    (a_mem)
    );

    hazard_src_cmp #(.ADDR_W(ADDR_W)) u_cmp_b (
        .valid_i      (hz.id_valid),
        .used_i       (hz.id_b_used),
        .addr_i       (hz.id_b_addr),
        .ex_addr_i    (hz.ex_c_addr),
        .ex_we_i      (hz.ex_reg_write),
        .ex_load_i    (hz.ex_data_read),
        .mem_addr_i   (hz.mem_c_addr),
        .mem_we_i     (hz.mem_reg_write),
        .ex_hit_o     (b_ex),
        .ex_load_hit_o(b_ld),
        .mem_hit_o    (b_mem)
    );

    // Stall only from RUN: in LOAD_STALL the load has moved to MEM and is forwarded instead.
    assign load_use = a_ld || b_ld;
    assign flush    = !RST && hz.branch_taken;
    assign stall    = !RST && !hz.branch_taken && (state_q == S_RUN) && load_use;
    assign bubble   = stall || flush;

    always_comb begin
        state_d     = (state_q == S_RUN) ? (hz.branch_taken ? S_FLUSH : load_use ? S_LOAD_STALL : S_RUN)
                    : (state_q == S_LOAD_STALL && hz.branch_taken) ? S_FLUSH : S_RUN;
        fwd_a_d     = bubble ? FWD_REG : fwd_encode(a_ex, a_ld, a_mem);
        fwd_b_d     = bubble ? FWD_REG : fwd_encode(b_ex, b_ld, b_mem);
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_RUN;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_pc    = stall;
    assign hz.stall_id    = stall;
    assign hz.flush_if_id = flush;
    assign hz.bubble_ex   = bubble;
    assign hz.fwd_a_sel   = fwd_a_q;
    assign hz.fwd_b_sel   = fwd_b_q;
    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: cycle-vector table with a forwarding scoreboard, plus counter saturation on a narrow-counter instance.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.ADDR_W(4), .CNT_W(16)) ifc ();
    pipeline_hazard_ctrl_if #(.ADDR_W(4), .CNT_W(2))  if2 ();

    pipeline_hazard_ctrl #(.ADDR_W(4), .CNT_W(16)) dut (.CLK(clk), .RST(rst), .hz(ifc.slave));
    pipeline_hazard_ctrl #(.ADDR_W(4), .CNT_W(2))  dut2 (.CLK(clk), .RST(rst), .hz(if2.slave));

    // ctrl = {stall_pc, stall_id, flush_if_id, bubble_ex}; fa/fb are the selects registered at the end of the cycle.
    typedef struct {
        string      name;
        logic       rst;
        logic       v;
        logic [3:0] aa;
        logic       au;
        logic [3:0] ba;
        logic       bu;
        logic [3:0] ec;
        logic       ew;
        logic       el;
        logic [3:0] mc;
        logic       mw;
        logic       br;
        logic [3:0] ctrl;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    vec_t       vq[$];
    logic [3:0] fwd_sb[$];

    function automatic vec_t mk(input string name, input logic r, input logic v, input logic [3:0] aa, input logic au,
                                input logic [3:0] ba, input logic bu, input logic [3:0] ec, input logic ew, input logic el,
                                input logic [3:0] mc, input logic mw, input logic br, input logic [3:0] ctrl,
                                input logic [1:0] fa, input logic [1:0] fb);
        vec_t t;
        t.name = name; t.rst = r; t.v = v; t.aa = aa; t.au = au; t.ba = ba; t.bu = bu;
        t.ec = ec; t.ew = ew; t.el = el; t.mc = mc; t.mw = mw; t.br = br;
        t.ctrl = ctrl; t.fa = fa; t.fb = fb;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst              = t.rst;
        ifc.id_valid     = t.v;
        ifc.id_a_addr    = t.aa;
        ifc.id_a_used    = t.au;
        ifc.id_b_addr    = t.ba;
        ifc.id_b_used    = t.bu;
        ifc.ex_c_addr    = t.ec;
        ifc.ex_reg_write = t.ew;
        ifc.ex_data_read = t.el;
        ifc.mem_c_addr   = t.mc;
        ifc.mem_reg_write = t.mw;
        ifc.branch_taken = t.br;
    endtask

    task automatic clr2();
        if2.id_valid = 0; if2.id_a_addr = 0; if2.id_a_used = 0; if2.id_b_addr = 0; if2.id_b_used = 0;
        if2.ex_c_addr = 0; if2.ex_reg_write = 0; if2.ex_data_read = 0;
        if2.mem_c_addr = 0; if2.mem_reg_write = 0; if2.branch_taken = 0;
    endtask

    initial begin
        int exp_sc = 0;
        int exp_fc = 0;
        logic [3:0] f;
        clr2();
        //                    name         rst v  aa au ba bu ec ew el mc mw br ctrl     fa fb
        vq.push_back(mk("reset",     1, 1, 3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("lu_det",    0, 1, 3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 4'b1101, 0, 0));
        vq.push_back(mk("lu_hold",   0, 1, 3, 1, 0, 0, 0, 0, 0, 3, 1, 0, 4'b0000, 2, 0));
        vq.push_back(mk("lu_ex",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("alu_fwd",   0, 1, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 4'b0000, 0, 1));
        vq.push_back(mk("alu_ex",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("r0_load",   0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("unused_b",  0, 1, 4, 0, 4, 0, 4, 1, 1, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("br_haz",    0, 1, 3, 1, 0, 0, 3, 1, 1, 0, 0, 1, 4'b0011, 0, 0));
        vq.push_back(mk("flush_st",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("dbl_hit",   0, 1, 7, 1, 0, 0, 7, 1, 0, 7, 1, 0, 4'b0000, 1, 0));
        vq.push_back(mk("mem_hit",   0, 1, 0, 0, 9, 1, 0, 0, 0, 9, 1, 0, 4'b0000, 0, 2));
        vq.push_back(mk("id_inval",  0, 0, 7, 1, 0, 0, 7, 1, 1, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("nop",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("lu2_det",   0, 1, 2, 1, 0, 0, 2, 1, 1, 0, 0, 0, 4'b1101, 0, 0));
        vq.push_back(mk("ls_branch", 0, 1, 2, 1, 0, 0, 0, 0, 0, 2, 1, 1, 4'b0011, 0, 0));
        vq.push_back(mk("flush2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("lu3_det",   0, 1, 6, 1, 0, 0, 6, 1, 1, 0, 0, 0, 4'b1101, 0, 0));
        vq.push_back(mk("rst_mid",   1, 1, 6, 1, 0, 0, 0, 0, 0, 6, 1, 0, 4'b0000, 0, 0));
        vq.push_back(mk("post_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        vq.push_back(mk("run_chk",   0, 1, 6, 1, 0, 0, 6, 1, 1, 0, 0, 0, 4'b1101, 0, 0));
        vq.push_back(mk("tail",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #2;
            chk({vq[i].name, "_ctrl"}, {ifc.stall_pc, ifc.stall_id, ifc.flush_if_id, ifc.bubble_ex}, vq[i].ctrl);
            if (fwd_sb.size() > 0) begin
                f = fwd_sb.pop_front();
                chk({vq[i].name, "_fwd"}, {ifc.fwd_a_sel, ifc.fwd_b_sel}, f);
            end
            if (i > 0) begin
                chk({vq[i].name, "_stall_cnt"}, ifc.stall_count, exp_sc);
                chk({vq[i].name, "_flush_cnt"}, ifc.flush_count, exp_fc);
            end
            fwd_sb.push_back({vq[i].fa, vq[i].fb});
            exp_sc = vq[i].rst ? 0 : exp_sc + int'(vq[i].ctrl[3]);
            exp_fc = vq[i].rst ? 0 : exp_fc + int'(vq[i].ctrl[1]);
        end

        // Narrow 2-bit counters reach all-ones quickly; further events must hold them there.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
            if2.id_valid = 1; if2.id_a_used = 1; if2.id_a_addr = 4'd3;
            if2.ex_c_addr = 4'd3; if2.ex_reg_write = 1; if2.ex_data_read = 1;
            #2 chk("sat_stall_pc", if2.stall_pc, 1);
            @(negedge clk);
            clr2();
            #2 chk("sat_stall_cnt", if2.stall_count, (k > 3) ? 3 : k);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if2.branch_taken = 1;
            #2 chk("sat_flush", if2.flush_if_id, 1);
            @(negedge clk);
            clr2();
            #2 chk("sat_flush_cnt", if2.flush_count, (k > 3) ? 3 : k);
        end
        chk("sat_stall_hold", if2.stall_count, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
